decode_stage_hs: RTL and testbench
==================================

Name: decode_stage_hs

Overview:
- Parametrised successor decode stage for the pipelined RV core. Sits between fetch and execute; in and out sides use valid/ready handshakes.
- Decodes one RV32I/RV64I instruction per cycle and generates all immediate formats at XLEN.
- Computes branch/jump targets; detects load-use hazards and inserts bubbles.
- Redirects fetch early on JAL; honours pipeline flush.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- EARLY_JAL, 1, 1: JAL redirects fetch from DE; 0: JAL is resolved in EX like other jumps.

Ports:
- CLK  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  kill the held instruction and the incoming one (EX/MEM redirect)
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  DE accepts this cycle
- in_pc  in  XLEN  PC of the fetched instruction
- in_ins  in  32  instruction word
- rs1_data  in  XLEN  register file read for in_ins[19:15] (combinational, same cycle)
- out_valid  out  1  EX register holds a valid instruction
- out_ready  in  1  EX consumes this cycle
- out_pc, out_imm, out_target  out  XLEN  registered PC, sign-extended immediate, branch/jump target
- out_rs1, out_rs2, out_rd  out  5  register indices
- out_opcode  out  7
- out_funct3  out  3
- out_funct7b5  out  1
- out_rwe, out_mwe, out_mre, out_be, out_jmp  out  1  register write, mem write, mem read, branch, jump enables
- jal_redirect  out  1  early JAL redirect strobe
- jal_pc  out  XLEN  redirect target

Behaviour:
- Reset: out_valid=0, every out_* data/enable=0, jal_redirect=0. in_ready follows its equation, so it reads 1 while out_valid=0 and no hazard exists.
- Acceptance: accept = in_valid & in_ready.
  - in_ready = (~out_valid | out_ready) & ~hazard & ~flush.
  - Latency: one cycle, accept at edge N gives out_valid at N+1.
- Holding: when out_valid & ~out_ready, all out_* hold unchanged.
- Hazard (load-use): out_valid & out_mre & out_rd!=0 & (out_rd==in_ins[19:15] | (in uses rs2 & out_rd==in_ins[24:20])).
  - rs2 is used by R, S and B formats only.
  - When hazard & out_ready: load a bubble at the edge (out_valid<=0, enables 0); the input is not accepted.
- Flush: at the next edge out_valid<=0 and all enables 0, regardless of out_ready. No acceptance that cycle. Flush has priority over hazard and handshake.
- Immediates: I, S, B, U and J formats, sign-extended to XLEN.
  - U: {ins[31:12],12'b0} sign-extended.
  - Unknown opcode: imm=0.
  - Illegal/unknown opcode: all enables 0, out_valid still 1 (EX traps).
- Target:
  - JALR: (rs1_data+imm) & ~1.
  - JAL and B: in_pc+imm.
  - Otherwise: in_pc+4.
  - All arithmetic mod 2^XLEN; wrap-around is silent.
- Enables:
  - rwe: LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP, and OP-32/OP-IMM-32 (XLEN=64 only); rwe is forced 0 when rd==0.
  - mwe: STORE.
  - mre: LOAD.
  - be: BRANCH.
  - jmp: JAL/JALR.
- Early JAL (EARLY_JAL=1): jal_redirect=1 for exactly the cycle a JAL is accepted (combinational from accept); jal_pc=in_pc+imm.
  - Never asserted during flush or hazard.
  - With EARLY_JAL=0, jal_redirect is tied 0.
- Simultaneous out_ready and accept: the register reloads with the new instruction with no bubble, giving full throughput.
- Reset mid-operation: all state clears immediately (asynchronous); in-flight instruction lost.

Decomposition:
- Package rv_pkg: opcode localparams (LOAD, STORE, BRANCH, JAL, JALR, OP, OP_IMM, OP_32, OP_IMM_32, LUI, AUIPC) and format codes.
- One sub-module imm_gen_xlen #(XLEN): combinational opcode -> format select -> sign-extended immediate. Reused by EX for checks.

Test Plan:
- Back-to-back ADDI x1,x0,5 (0x00500093) at pc 0x100 then ADD x2,x1,x1 with out_ready=1 -> out_valid two consecutive cycles; imm=5, rd=1, rwe=1; second instruction rs1=rs2=1, no bubble.
- LW x3,0(x1) then ADD x4,x3,x0 -> exactly one bubble (out_valid=0 one cycle, in_ready=0); ADD issues next cycle.
- JAL x1,+0x20 at pc 0x200, EARLY_JAL=1 -> jal_redirect pulse in the accept cycle, jal_pc=0x220, out_target=0x220, out_rwe=1.
- JALR x0,-1(x5) with rs1_data=0x1000 -> out_target=0xFFE, out_rwe=0 (rd=0).
- out_ready=0 for 3 cycles with a valid held instruction -> outputs stable, in_ready=0; flush asserted -> out_valid=0 next edge.
- XLEN=64: LUI x1,0x80000 -> out_imm=0xFFFFFFFF80000000; BEQ at pc 0xFFFFFFFFFFFFFFF8 with imm +16 -> target wraps to 0x8.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV32I/RV64I decode constants: major opcodes and instruction formats.
// Imported by the decode stage and by the immediate generator that EX reuses.
package rv_pkg;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;

  typedef enum logic [2:0] {
    FMT_NONE,
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J
  } fmt_e;

  // FMT_NONE doubles as "illegal opcode"; the word ops only exist on RV64.
  function automatic fmt_e fmt_of(input logic [6:0] opc, input logic rv64);
    fmt_e f;
    case (opc)
      OPC_OP:                           f = FMT_R;
      OPC_OP_32:                        f = rv64 ? FMT_R : FMT_NONE;
      OPC_LOAD, OPC_OP_IMM, OPC_JALR:   f = FMT_I;
      OPC_OP_IMM_32:                    f = rv64 ? FMT_I : FMT_NONE;
      OPC_STORE:                        f = FMT_S;
      OPC_BRANCH:                       f = FMT_B;
      OPC_LUI, OPC_AUIPC:               f = FMT_U;
      OPC_JAL:                          f = FMT_J;
      default:                          f = FMT_NONE;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/imm_gen_xlen.sv
// Combinational immediate generator: opcode -> format -> sign-extended XLEN immediate.
// Formats without an immediate (R, unknown) yield zero.
module imm_gen_xlen
  import rv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     ins,
  output fmt_e            fmt,
  output logic [XLEN-1:0] imm
);

  logic signed [31:0] imm32;

  assign fmt = fmt_of(ins[6:0], XLEN == 64);

  always_comb begin
    // NOTE: default assignment first so every path drives imm32 and no latch is inferred.
    imm32 = '0;
    case (fmt)
      FMT_I:   imm32 = {{20{ins[31]}}, ins[31:20]};
      FMT_S:   imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      FMT_B:   imm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      FMT_U:   imm32 = {ins[31:12], 12'b0};
      FMT_J:   imm32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  // Size cast of a signed operand sign-extends to XLEN.
  assign imm = XLEN'(imm32);

endmodule

// File: rtl/decode_stage_hs.sv
// Decode stage between fetch and execute with valid/ready on both sides,
// load-use bubble insertion, flush, and optional early JAL redirect.
module decode_stage_hs
  import rv_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter bit EARLY_JAL = 1'b1
) (
  input  logic            CLK,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_ins,
  input  logic [XLEN-1:0] rs1_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_target,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic            out_funct7b5,
  output logic            out_rwe,
  output logic            out_mwe,
  output logic            out_mre,
  output logic            out_be,
  output logic            out_jmp,
  output logic            jal_redirect,
  output logic [XLEN-1:0] jal_pc
);

  localparam logic [XLEN-1:0] FOUR     = XLEN'(4);
  localparam logic [XLEN-1:0] LSB_MASK = ~XLEN'(1);

  logic [6:0]      opc;
  logic [4:0]      rd, rs1, rs2;
  fmt_e            fmt;
  logic [XLEN-1:0] imm, pc_imm, target;
  logic            uses_rs2, hazard, accept, legal;
  logic            rwe, mwe, mre, be, jmp;

  assign opc = in_ins[6:0];
  assign rd  = in_ins[11:7];
  assign rs1 = in_ins[19:15];
  assign rs2 = in_ins[24:20];

  imm_gen_xlen #(.XLEN(XLEN)) u_imm (
    .ins (in_ins),
    .fmt (fmt),
    .imm (imm)
  );

  // Load-use: the load in the EX register has not produced its data yet.
  assign uses_rs2 = fmt inside {FMT_R, FMT_S, FMT_B};
  assign hazard   = out_valid & out_mre & (out_rd != 5'd0) &
                    ((out_rd == rs1) | (uses_rs2 & (out_rd == rs2)));
  assign in_ready = (~out_valid | out_ready) & ~hazard & ~flush;
  assign accept   = in_valid & in_ready;

  // fmt_of only returns a real format for opcodes this core implements.
  assign legal = (fmt != FMT_NONE);
  assign rwe   = legal & (opc != OPC_STORE) & (opc != OPC_BRANCH) & (rd != 5'd0);
  assign mwe   = (opc == OPC_STORE);
  assign mre   = (opc == OPC_LOAD);
  assign be    = (opc == OPC_BRANCH);
  assign jmp   = (opc == OPC_JAL) | (opc == OPC_JALR);

  assign pc_imm = in_pc + imm;
  assign target = (opc == OPC_JALR)                        ? ((rs1_data + imm) & LSB_MASK) :
                  ((opc == OPC_JAL) | (opc == OPC_BRANCH)) ? pc_imm :
                                                             in_pc + FOUR;

  assign jal_redirect = EARLY_JAL & accept & (opc == OPC_JAL);
  assign jal_pc       = EARLY_JAL ? pc_imm : '0;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_pc       <= '0;
      out_imm      <= '0;
      out_target   <= '0;
      out_rs1      <= '0;
      out_rs2      <= '0;
      out_rd       <= '0;
      out_opcode   <= '0;
      out_funct3   <= '0;
      out_funct7b5 <= 1'b0;
      out_rwe      <= 1'b0;
      out_mwe      <= 1'b0;
      out_mre      <= 1'b0;
      out_be       <= 1'b0;
      out_jmp      <= 1'b0;
    end else if (flush || (!accept && out_ready)) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      out_valid <= 1'b0;
      out_rwe   <= 1'b0;
      out_mwe   <= 1'b0;
      out_mre   <= 1'b0;
      out_be    <= 1'b0;
      out_jmp   <= 1'b0;
    end else if (accept) begin
      out_valid    <= 1'b1;
      out_pc       <= in_pc;
      out_imm      <= imm;
      out_target   <= target;
      out_rs1      <= rs1;
      out_rs2      <= rs2;
      out_rd       <= rd;
      out_opcode   <= opc;
      out_funct3   <= in_ins[14:12];
      out_funct7b5 <= in_ins[30];
      out_rwe      <= rwe;
      out_mwe      <= mwe;
      out_mre      <= mre;
      out_be       <= be;
      out_jmp      <= jmp;
    end
  end

endmodule

// File: tb/tb_decode_stage_hs.sv
// Scoreboard bench for decode_stage_hs: one XLEN=32 (early JAL) and one XLEN=64
// (late JAL) instance fed hand-encoded instructions with hand-computed results.
module tb_decode_stage_hs;
  import rv_pkg::*;

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] imm;
    logic [63:0] target;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        f7b5;
    logic [4:0]  en;   // {rwe, mwe, mre, be, jmp}
  } exp_t;

  logic CLK = 1'b0;
  logic rst_n = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  exp_t sb_a[$];
  exp_t sb_b[$];

  // XLEN=32, EARLY_JAL=1
  logic        flush_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a;
  logic [31:0] in_pc_a, in_ins_a, rs1_a, out_pc_a, out_imm_a, out_target_a, jal_pc_a;
  logic [4:0]  out_rs1_a, out_rs2_a, out_rd_a;
  logic [6:0]  out_opcode_a;
  logic [2:0]  out_funct3_a;
  logic        out_funct7b5_a, out_rwe_a, out_mwe_a, out_mre_a, out_be_a, out_jmp_a, jal_redirect_a;

  // XLEN=64, EARLY_JAL=0
  logic        flush_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b;
  logic [63:0] in_pc_b, rs1_b, out_pc_b, out_imm_b, out_target_b, jal_pc_b;
  logic [31:0] in_ins_b;
  logic [4:0]  out_rs1_b, out_rs2_b, out_rd_b;
  logic [6:0]  out_opcode_b;
  logic [2:0]  out_funct3_b;
  logic        out_funct7b5_b, out_rwe_b, out_mwe_b, out_mre_b, out_be_b, out_jmp_b, jal_redirect_b;

  decode_stage_hs #(.XLEN(32), .EARLY_JAL(1'b1)) dut_a (
    .CLK(CLK), .rst_n(rst_n), .flush(flush_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_pc(in_pc_a), .in_ins(in_ins_a), .rs1_data(rs1_a), .out_valid(out_valid_a),
    .out_ready(out_ready_a), .out_pc(out_pc_a), .out_imm(out_imm_a), .out_target(out_target_a),
    .out_rs1(out_rs1_a), .out_rs2(out_rs2_a), .out_rd(out_rd_a), .out_opcode(out_opcode_a),
    .out_funct3(out_funct3_a), .out_funct7b5(out_funct7b5_a), .out_rwe(out_rwe_a),
    .out_mwe(out_mwe_a), .out_mre(out_mre_a), .out_be(out_be_a), .out_jmp(out_jmp_a),
    .jal_redirect(jal_redirect_a), .jal_pc(jal_pc_a)
  );

  decode_stage_hs #(.XLEN(64), .EARLY_JAL(1'b0)) dut_b (
    .CLK(CLK), .rst_n(rst_n), .flush(flush_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_pc(in_pc_b), .in_ins(in_ins_b), .rs1_data(rs1_b), .out_valid(out_valid_b),
    .out_ready(out_ready_b), .out_pc(out_pc_b), .out_imm(out_imm_b), .out_target(out_target_b),
    .out_rs1(out_rs1_b), .out_rs2(out_rs2_b), .out_rd(out_rd_b), .out_opcode(out_opcode_b),
    .out_funct3(out_funct3_b), .out_funct7b5(out_funct7b5_b), .out_rwe(out_rwe_b),
    .out_mwe(out_mwe_b), .out_mre(out_mre_b), .out_be(out_be_b), .out_jmp(out_jmp_b),
    .jal_redirect(jal_redirect_b), .jal_pc(jal_pc_b)
  );

  exp_t act_a, act_b;
  always_comb begin
    act_a        = '0;
    act_a.pc     = 64'(out_pc_a);
    act_a.imm    = 64'(out_imm_a);
    act_a.target = 64'(out_target_a);
    act_a.rd     = out_rd_a;
    act_a.rs1    = out_rs1_a;
    act_a.rs2    = out_rs2_a;
    act_a.opc    = out_opcode_a;
    act_a.f3     = out_funct3_a;
    act_a.f7b5   = out_funct7b5_a;
    act_a.en     = {out_rwe_a, out_mwe_a, out_mre_a, out_be_a, out_jmp_a};
  end
  always_comb begin
    act_b        = '0;
    act_b.pc     = out_pc_b;
    act_b.imm    = out_imm_b;
    act_b.target = out_target_b;
    act_b.rd     = out_rd_b;
    act_b.rs1    = out_rs1_b;
    act_b.rs2    = out_rs2_b;
    act_b.opc    = out_opcode_b;
    act_b.f3     = out_funct3_b;
    act_b.f7b5   = out_funct7b5_b;
    act_b.en     = {out_rwe_b, out_mwe_b, out_mre_b, out_be_b, out_jmp_b};
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp(input string tag, input exp_t a, input exp_t e);
    check({tag, ".pc"},     a.pc, e.pc);
    check({tag, ".imm"},    a.imm, e.imm);
    check({tag, ".target"}, a.target, e.target);
    check({tag, ".regs"},   64'({a.rd, a.rs1, a.rs2}), 64'({e.rd, e.rs1, e.rs2}));
    check({tag, ".fields"}, 64'({a.opc, a.f3, a.f7b5}), 64'({e.opc, e.f3, e.f7b5}));
    check({tag, ".enables"}, 64'(a.en), 64'(e.en));
  endtask

  function automatic exp_t mk(input logic [63:0] pc, input logic [63:0] imm,
                              input logic [63:0] tgt, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [6:0] opc, input logic [2:0] f3,
                              input logic f7b5, input logic [4:0] en);
    exp_t e;
    e.pc = pc; e.imm = imm; e.target = tgt; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2;
    e.opc = opc; e.f3 = f3; e.f7b5 = f7b5; e.en = en;
    return e;
  endfunction

  // Monitors: a transfer to EX happens at the edge following a negedge with valid & ready.
  always @(negedge CLK) begin
    if (rst_n && out_valid_a && out_ready_a && !flush_a) begin
      if (sb_a.size() == 0) begin
        checks++; errors++;
        $display("FAIL d32_unexpected: got output pc %h, required no output", out_pc_a);
      end else cmp("d32", act_a, sb_a.pop_front());
    end
  end
  always @(negedge CLK) begin
    if (rst_n && out_valid_b && out_ready_b && !flush_b) begin
      if (sb_b.size() == 0) begin
        checks++; errors++;
        $display("FAIL d64_unexpected: got output pc %h, required no output", out_pc_b);
      end else cmp("d64", act_b, sb_b.pop_front());
    end
  end

  task automatic send(input bit sel, input logic [63:0] pc, input logic [31:0] ins,
                      input logic [63:0] r1, input exp_t e, output int waits, output logic ov);
    logic rdy, red, exp_red;
    waits = 0; ov = 1'b0; rdy = 1'b0;
    if (sel) begin
      in_valid_b = 1'b1; in_ins_b = ins; in_pc_b = pc; rs1_b = r1;
    end else begin
      in_valid_a = 1'b1; in_ins_a = ins; in_pc_a = pc[31:0]; rs1_a = r1[31:0];
    end
    while (!rdy && waits < 20) begin
      @(negedge CLK);
      waits++;
      rdy     = sel ? in_ready_b : in_ready_a;
      red     = sel ? jal_redirect_b : jal_redirect_a;
      exp_red = !sel && rdy && (ins[6:0] == OPC_JAL);
      check("jal_redirect", 64'(red), 64'(exp_red));
    end
    if (!rdy) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready stayed 0 for pc %h, required 1", pc);
    end else begin
      ov = sel ? out_valid_b : out_valid_a;
      if (sel) sb_b.push_back(e); else sb_a.push_back(e);
      if (!sel && ins[6:0] == OPC_JAL) check("jal_pc", 64'(jal_pc_a), e.target);
    end
    @(posedge CLK); #1;
    if (sel) in_valid_b = 1'b0; else in_valid_a = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int   w;
    logic ov;
    flush_a = 0; in_valid_a = 0; in_pc_a = '0; in_ins_a = '0; rs1_a = '0; out_ready_a = 1;
    flush_b = 0; in_valid_b = 0; in_pc_b = '0; in_ins_b = '0; rs1_b = '0; out_ready_b = 1;
    repeat (2) @(posedge CLK);
    #1 rst_n = 1'b1;

    @(negedge CLK);
    check("rst_out_valid_a", 64'(out_valid_a), 64'd0);
    check("rst_enables_a", 64'(act_a.en), 64'd0);
    check("rst_out_pc_a", 64'(out_pc_a), 64'd0);
    check("rst_in_ready_a", 64'(in_ready_a), 64'd1);
    check("rst_redirect_a", 64'(jal_redirect_a), 64'd0);
    check("rst_out_valid_b", 64'(out_valid_b), 64'd0);
    check("rst_in_ready_b", 64'(in_ready_b), 64'd1);
    @(posedge CLK); #1;

    // ADDI x1,x0,5 then ADD x2,x1,x1 back-to-back
    send(0, 64'h100, 32'h00500093, 64'h0, mk(64'h100, 64'd5, 64'h104, 5'd1, 5'd0, 5'd5, 7'h13, 3'd0, 1'b0, 5'b10000), w, ov);
    send(0, 64'h104, 32'h00108133, 64'h0, mk(64'h104, 64'd0, 64'h108, 5'd2, 5'd1, 5'd1, 7'h33, 3'd0, 1'b0, 5'b10000), w, ov);
    check("b2b_waits", 64'(w), 64'd1);
    check("b2b_prev_valid", 64'(ov), 64'd1);

    // LW x3,0(x1) then ADD x4,x3,x0: one bubble
    send(0, 64'h108, 32'h0000A183, 64'h0, mk(64'h108, 64'd0, 64'h10C, 5'd3, 5'd1, 5'd0, 7'h03, 3'd2, 1'b0, 5'b10100), w, ov);
    send(0, 64'h10C, 32'h00018233, 64'h0, mk(64'h10C, 64'd0, 64'h110, 5'd4, 5'd3, 5'd0, 7'h33, 3'd0, 1'b0, 5'b10000), w, ov);
    check("lu_waits", 64'(w), 64'd2);
    check("lu_bubble", 64'(ov), 64'd0);

    // LW x5 then ADDI x6,x0,5: rs2 field matches but I-format, no hazard
    send(0, 64'h110, 32'h00402283, 64'h0, mk(64'h110, 64'd4, 64'h114, 5'd5, 5'd0, 5'd4, 7'h03, 3'd2, 1'b0, 5'b10100), w, ov);
    send(0, 64'h114, 32'h00500313, 64'h0, mk(64'h114, 64'd5, 64'h118, 5'd6, 5'd0, 5'd5, 7'h13, 3'd0, 1'b0, 5'b10000), w, ov);
    check("no_haz_waits", 64'(w), 64'd1);

    // JAL x1,+0x20; JALR x0,-1(x5); SW x2,-4(x1); illegal; ADDIW on RV32 (illegal)
    send(0, 64'h200, 32'h020000EF, 64'h0, mk(64'h200, 64'h20, 64'h220, 5'd1, 5'd0, 5'd0, 7'h6F, 3'd0, 1'b0, 5'b10001), w, ov);
    send(0, 64'h300, 32'hFFF28067, 64'h1000, mk(64'h300, 64'hFFFFFFFF, 64'hFFE, 5'd0, 5'd5, 5'd31, 7'h67, 3'd0, 1'b1, 5'b00001), w, ov);
    send(0, 64'h400, 32'hFE20AE23, 64'h0, mk(64'h400, 64'hFFFFFFFC, 64'h404, 5'd28, 5'd1, 5'd2, 7'h23, 3'd2, 1'b1, 5'b01000), w, ov);
    send(0, 64'h500, 32'hFFFFFFFF, 64'h0, mk(64'h500, 64'd0, 64'h504, 5'd31, 5'd31, 5'd31, 7'h7F, 3'd7, 1'b1, 5'b00000), w, ov);
    send(0, 64'h504, 32'hFFF0809B, 64'h0, mk(64'h504, 64'd0, 64'h508, 5'd1, 5'd1, 5'd31, 7'h1B, 3'd0, 1'b1, 5'b00000), w, ov);
    repeat (3) @(posedge CLK);
    #1;
    check("drain_a", 64'(sb_a.size()), 64'd0);

    // Hold with out_ready=0, then flush while a JAL is waiting at the input
    out_ready_a = 1'b0;
    send(0, 64'h600, 32'h00100393, 64'h0, mk(64'h600, 64'd1, 64'h604, 5'd7, 5'd0, 5'd1, 7'h13, 3'd0, 1'b0, 5'b10000), w, ov);
    in_valid_a = 1'b1; in_ins_a = 32'h020000EF; in_pc_a = 32'h700;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("hold_in_ready", 64'(in_ready_a), 64'd0);
      check("hold_valid", 64'(out_valid_a), 64'd1);
      check("hold_pc", 64'(out_pc_a), 64'h600);
      check("hold_imm", 64'(out_imm_a), 64'd1);
      check("hold_target", 64'(out_target_a), 64'h604);
      check("hold_redirect", 64'(jal_redirect_a), 64'd0);
    end
    @(posedge CLK); #1 flush_a = 1'b1;
    @(negedge CLK);
    check("flush_in_ready", 64'(in_ready_a), 64'd0);
    check("flush_redirect", 64'(jal_redirect_a), 64'd0);
    @(posedge CLK); #1 flush_a = 1'b0; in_valid_a = 1'b0;
    @(negedge CLK);
    check("flush_valid", 64'(out_valid_a), 64'd0);
    check("flush_enables", 64'(act_a.en), 64'd0);
    sb_a.delete();
    @(posedge CLK); #1 out_ready_a = 1'b1;

    // Load-use through rs2 of a store
    send(0, 64'h800, 32'h00402283, 64'h0, mk(64'h800, 64'd4, 64'h804, 5'd5, 5'd0, 5'd4, 7'h03, 3'd2, 1'b0, 5'b10100), w, ov);
    send(0, 64'h804, 32'h00512023, 64'h0, mk(64'h804, 64'd0, 64'h808, 5'd0, 5'd2, 5'd5, 7'h23, 3'd2, 1'b0, 5'b01000), w, ov);
    check("rs2_haz_waits", 64'(w), 64'd2);
    repeat (2) @(posedge CLK);
    #1;

    // Asynchronous reset with an instruction held
    out_ready_a = 1'b0;
    send(0, 64'h900, 32'h00100393, 64'h0, mk(64'h900, 64'd1, 64'h904, 5'd7, 5'd0, 5'd1, 7'h13, 3'd0, 1'b0, 5'b10000), w, ov);
    @(negedge CLK);
    check("pre_rst_valid", 64'(out_valid_a), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(out_valid_a), 64'd0);
    check("async_rst_pc", 64'(out_pc_a), 64'd0);
    sb_a.delete();
    out_ready_a = 1'b1;
    @(posedge CLK); #1 rst_n = 1'b1;

    // RV64 instance
    send(1, 64'h1000, 32'h800000B7, 64'h0, mk(64'h1000, 64'hFFFFFFFF80000000, 64'h1004, 5'd1, 5'd0, 5'd0, 7'h37, 3'd0, 1'b0, 5'b10000), w, ov);
    send(1, 64'hFFFFFFFFFFFFFFF8, 32'h00000863, 64'h0, mk(64'hFFFFFFFFFFFFFFF8, 64'h10, 64'h8, 5'd16, 5'd0, 5'd0, 7'h63, 3'd0, 1'b0, 5'b00010), w, ov);
    send(1, 64'h2000, 32'hFFF0809B, 64'h0, mk(64'h2000, 64'hFFFFFFFFFFFFFFFF, 64'h2004, 5'd1, 5'd1, 5'd31, 7'h1B, 3'd0, 1'b1, 5'b10000), w, ov);
    send(1, 64'h200, 32'h020000EF, 64'h0, mk(64'h200, 64'h20, 64'h220, 5'd1, 5'd0, 5'd0, 7'h6F, 3'd0, 1'b0, 5'b10001), w, ov);
    repeat (3) @(posedge CLK);
    #1;
    check("drain_b", 64'(sb_b.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
